// File: rtl/tl_pkg.sv
// TileLink-UL channel types and opcode constants shared by peripherals on the
// peripheral bus.
package tl_pkg;

    localparam logic [2:0] TL_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        a_ready;
    } tilelink_a;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [1:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        d_ready;
    } tilelink_d;

endpackage

// File: rtl/uart_pkg.sv
// UART register offsets, STATUS bit positions and serial FSM state encodings.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_FULL   = 2;
    localparam int ST_RX_EMPTY  = 3;
    localparam int ST_OVERRUN   = 4;
    localparam int ST_TX_BUSY   = 5;
    localparam int ST_FRAME_ERR = 6;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data. A push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // NOTE: storage is left unreset; the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/tl_uart.sv
// TL-UL slave UART: 8N1 transmitter and receiver behind DATA/STATUS/DIV
// registers, with TX/RX FIFOs and a runtime baud divisor.
module tl_uart
    import tl_pkg::*;
    import uart_pkg::*;
#(
    parameter int                 FIFO_DEPTH = 8,
    parameter int                 DIV_WIDTH  = 16,
    parameter logic [DIV_WIDTH-1:0] RESET_DIV = DIV_WIDTH'(15)
) (
    input  logic      clock,
    input  logic      reset,
    input  tilelink_a tla,
    output logic      a_ready,
    output tilelink_d tld,
    input  logic      d_ready,
    input  logic      uart_rx,
    output logic      uart_tx,
    output logic      irq
);

    tilelink_d            tld_q, tld_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 overrun_q, overrun_d, frame_err_q, frame_err_d, irq_q;

    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] tx_rdata, rx_rdata;
    logic [6:0] status;
    logic       accept, is_get, is_put, sticky_clr, frame_set, overrun_set, unused_tla;
    logic [1:0] reg_sel;

    tx_state_e            tx_state_q;
    logic [DIV_WIDTH-1:0] tx_timer_q;
    logic [2:0]           tx_cnt_q;
    logic [7:0]           tx_shift_q;
    logic                 tx_line_q, tx_bit_end;

    rx_state_e            rx_state_q;
    logic [DIV_WIDTH-1:0] rx_timer_q, rx_half_load;
    logic [DIV_WIDTH:0]   rx_half;
    logic [2:0]           rx_cnt_q;
    logic [7:0]           rx_shift_q;
    logic [1:0]           rx_sync_q;
    logic                 rx_prev_q, rx_s, rx_bit_end;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock(clock), .reset(reset), .push(tx_push), .pop(tx_pop),
        .wdata(tla.a_data[7:0]), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock(clock), .reset(reset), .push(rx_push), .pop(rx_pop),
        .wdata(rx_shift_q), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
    );

    assign unused_tla = ^tla;
    assign a_ready    = !reset && !tld_q.d_valid;
    assign accept     = tla.a_valid && a_ready;
    assign reg_sel    = tla.a_address[3:2];
    assign is_get     = (tla.a_opcode == TL_GET);
    assign is_put     = (tla.a_opcode == TL_PUT_FULL) || (tla.a_opcode == TL_PUT_PARTIAL);
    assign status     = {frame_err_q, (tx_state_q != TX_IDLE), overrun_q,
                         rx_empty, rx_full, tx_empty, tx_full};

    // NOTE: every output of this block gets a default first, so no latch can form.
    always_comb begin
        tld_d      = tld_q;
        div_d      = div_q;
        tx_push    = 1'b0;
        rx_pop     = 1'b0;
        sticky_clr = 1'b0;
        if (tld_q.d_valid && d_ready) tld_d.d_valid = 1'b0;
        if (accept) begin
            tld_d          = '0;
            tld_d.d_valid  = 1'b1;
            tld_d.d_source = tla.a_source;
            tld_d.d_size   = tla.a_size;
            tld_d.d_opcode = TL_ACCESS_ACK;
            if (is_get) begin
                tld_d.d_opcode = TL_ACCESS_ACK_DATA;
                case (reg_sel)
                    REG_DATA: begin
                        rx_pop        = !rx_empty;
                        tld_d.d_data  = rx_empty ? 32'd0 : {24'd0, rx_rdata};
                    end
                    REG_STATUS: begin
                        tld_d.d_data = {25'd0, status};
                        sticky_clr   = 1'b1;
                    end
                    REG_DIV: tld_d.d_data  = 32'(div_q);
                    default: tld_d.d_error = 1'b1;
                endcase
            end else if (is_put) begin
                case (reg_sel)
                    REG_DATA: begin
                        if (tla.a_mask[0]) begin
                            // Fullness is judged before any same-cycle FSM pop.
                            if (tx_full) tld_d.d_error = 1'b1;
                            else         tx_push       = 1'b1;
                        end
                    end
                    REG_DIV: begin
                        for (int i = 0; i < DIV_WIDTH/8; i++)
                            if (tla.a_mask[i]) div_d[8*i +: 8] = tla.a_data[8*i +: 8];
                    end
                    REG_RSVD: tld_d.d_error = 1'b1;
                    default: ;
                endcase
            end else begin
                tld_d.d_error = 1'b1;
            end
        end
    end

    assign overrun_set = rx_push && rx_full && !rx_pop;
    assign overrun_d   = overrun_set || (overrun_q && !sticky_clr);
    assign frame_err_d = frame_set || (frame_err_q && !sticky_clr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tld_q       <= '0;
            div_q       <= RESET_DIV;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            tld_q       <= tld_d;
            div_q       <= div_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            irq_q       <= !rx_empty || overrun_q || frame_err_q;
        end
    end

    assign tld = tld_q;
    assign irq = irq_q;

    // The bit timer reloads from div_q at each bit boundary, so a DIV write
    // only affects the next bit.
    assign tx_bit_end = (tx_timer_q == '0);
    assign tx_pop     = !tx_empty && ((tx_state_q == TX_IDLE) ||
                                      (tx_state_q == TX_STOP && tx_bit_end));
    assign uart_tx    = tx_line_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_timer_q <= '0;
            tx_cnt_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            if (tx_state_q != TX_IDLE) tx_timer_q <= tx_timer_q - DIV_WIDTH'(1);
            case (tx_state_q)
                TX_IDLE: if (!tx_empty) begin
                    tx_shift_q <= tx_rdata;
                    tx_line_q  <= 1'b0;
                    tx_timer_q <= div_q;
                    tx_state_q <= TX_START;
                end
                TX_START: if (tx_bit_end) begin
                    tx_line_q  <= tx_shift_q[0];
                    tx_shift_q <= tx_shift_q >> 1;
                    tx_cnt_q   <= '0;
                    tx_timer_q <= div_q;
                    tx_state_q <= TX_DATA;
                end
                TX_DATA: if (tx_bit_end) begin
                    tx_timer_q <= div_q;
                    if (tx_cnt_q == 3'd7) begin
                        tx_line_q  <= 1'b1;
                        tx_state_q <= TX_STOP;
                    end else begin
                        tx_line_q  <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_cnt_q   <= tx_cnt_q + 3'd1;
                    end
                end
                TX_STOP: if (tx_bit_end) begin
                    if (!tx_empty) begin
                        tx_shift_q <= tx_rdata;
                        tx_line_q  <= 1'b0;
                        tx_timer_q <= div_q;
                        tx_state_q <= TX_START;
                    end else begin
                        tx_state_q <= TX_IDLE;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign rx_s         = rx_sync_q[1];
    assign rx_bit_end   = (rx_timer_q == '0);
    assign rx_half      = ({1'b0, div_q} + (DIV_WIDTH+1)'(1)) >> 1;
    assign rx_half_load = (rx_half == '0) ? '0 : DIV_WIDTH'(rx_half - (DIV_WIDTH+1)'(1));
    assign rx_push      = (rx_state_q == RX_STOP) && rx_bit_end && rx_s;
    assign frame_set    = (rx_state_q == RX_STOP) && rx_bit_end && !rx_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_timer_q <= '0;
            rx_cnt_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], uart_rx};
            rx_prev_q <= rx_s;
            if (rx_state_q != RX_IDLE) rx_timer_q <= rx_timer_q - DIV_WIDTH'(1);
            case (rx_state_q)
                RX_IDLE: if (rx_prev_q && !rx_s) begin
                    rx_timer_q <= rx_half_load;
                    rx_state_q <= RX_START;
                end
                RX_START: if (rx_bit_end) begin
                    rx_cnt_q   <= '0;
                    rx_timer_q <= div_q;
                    rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_bit_end) begin
                    rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                    rx_timer_q <= div_q;
                    rx_cnt_q   <= rx_cnt_q + 3'd1;
                    if (rx_cnt_q == 3'd7) rx_state_q <= RX_STOP;
                end
                RX_STOP: if (rx_bit_end) rx_state_q <= RX_IDLE;
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_uart.sv
// Directed self-checking bench for tl_uart: bus handshake, register access,
// serial framing at DIV=3, loopback reception, overrun and mid-frame reset.
module tb_tl_uart;
    import tl_pkg::*;

    logic      clock = 1'b0;
    logic      reset;
    tilelink_a tla;
    logic      a_ready;
    tilelink_d tld;
    logic      d_ready;
    logic      uart_rx, uart_tx, irq;
    logic      loop_en, rx_man;
    int        passed = 0;
    int        total  = 0;

    assign uart_rx = loop_en ? uart_tx : rx_man;
    always #5 clock = ~clock;

    tl_uart #(.FIFO_DEPTH(8), .DIV_WIDTH(16), .RESET_DIV(16'd15)) dut (
        .clock(clock), .reset(reset), .tla(tla), .a_ready(a_ready), .tld(tld),
        .d_ready(d_ready), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic bus(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] data, output tilelink_d rsp);
        int n;
        @(negedge clock);
        tla           = '0;
        tla.a_valid   = 1'b1;
        tla.a_opcode  = op;
        tla.a_size    = 2'd2;
        tla.a_source  = 8'h5A;
        tla.a_address = addr;
        tla.a_mask    = mask;
        tla.a_data    = data;
        n = 0;
        while (!a_ready && n < 50) begin @(negedge clock); n++; end
        @(negedge clock);
        tla.a_valid = 1'b0;
        n = 0;
        while (!tld.d_valid && n < 50) begin @(negedge clock); n++; end
        check("rsp_valid", 32'(tld.d_valid), 32'd1);
        rsp = tld;
    endtask

    task automatic wait_tx_fall();
        int n;
        n = 0;
        while (uart_tx !== 1'b0 && n < 100) begin @(negedge clock); n++; end
        check("tx_start_seen", 32'(uart_tx), 32'd0);
    endtask

    task automatic poll_rx();
        tilelink_d r;
        int n;
        n = 0;
        r = '0;
        r.d_data = 32'h8;
        while (r.d_data[3] !== 1'b0 && n < 100) begin
            bus(TL_GET, 32'h4, 4'hF, 32'd0, r);
            n++;
        end
        check("rx_arrived", 32'(r.d_data[3]), 32'd0);
    endtask

    initial begin
        tilelink_d  r;
        logic [9:0] frame;
        tla     = '0;
        d_ready = 1'b1;
        loop_en = 1'b0;
        rx_man  = 1'b1;
        reset   = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_d_valid", 32'(tld.d_valid), 32'd0);
        check("rst_d_data", tld.d_data, 32'd0);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("a_ready_after_rst", 32'(a_ready), 32'd1);

        bus(TL_GET, 32'h8, 4'hF, 32'd0, r);
        check("div_reset", r.d_data, 32'd15);
        check("div_get_opcode", 32'(r.d_opcode), 32'(TL_ACCESS_ACK_DATA));
        check("echo_source", 32'(r.d_source), 32'h5A);
        check("echo_size", 32'(r.d_size), 32'd2);
        check("d_param_sink", {r.d_param, r.d_sink}, 32'd0);

        bus(TL_PUT_FULL, 32'h8, 4'hF, 32'd3, r);
        check("div_put_opcode", 32'(r.d_opcode), 32'(TL_ACCESS_ACK));
        check("div_put_err", 32'(r.d_error), 32'd0);
        bus(TL_GET, 32'hB, 4'hF, 32'd0, r);
        check("div_readback_lowbits_ignored", r.d_data, 32'd3);

        // Bit-accurate transmit of 0x55 at four clocks per bit.
        bus(TL_PUT_FULL, 32'h0, 4'h1, 32'h55, r);
        check("tx_put_err", 32'(r.d_error), 32'd0);
        check("tx_put_data", r.d_data, 32'd0);
        wait_tx_fall();
        frame = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 40; k++) begin
            check("tx_bit", 32'(uart_tx), 32'(frame[k/4]));
            @(negedge clock);
        end
        check("tx_idle_after", 32'(uart_tx), 32'd1);

        // Empty reads, reserved offset, illegal opcode.
        bus(TL_GET, 32'h0, 4'hF, 32'd0, r);
        check("rx_empty_data", r.d_data, 32'd0);
        check("rx_empty_err", 32'(r.d_error), 32'd0);
        check("rx_empty_opcode", 32'(r.d_opcode), 32'(TL_ACCESS_ACK_DATA));
        bus(TL_GET, 32'hC, 4'hF, 32'd0, r);
        check("rsvd_err", 32'(r.d_error), 32'd1);
        check("rsvd_data", r.d_data, 32'd0);
        bus(3'd2, 32'h0, 4'h1, 32'h77, r);
        check("bad_op_err", 32'(r.d_error), 32'd1);
        check("bad_op_opcode", 32'(r.d_opcode), 32'(TL_ACCESS_ACK));
        bus(TL_GET, 32'h4, 4'hF, 32'd0, r);
        check("status_idle", r.d_data, 32'h0A);

        // Loopback of two bytes.
        loop_en = 1'b1;
        bus(TL_PUT_FULL, 32'h0, 4'h1, 32'hA3, r);
        bus(TL_PUT_PARTIAL, 32'h0, 4'h1, 32'h3C, r);
        poll_rx();
        bus(TL_GET, 32'h0, 4'hF, 32'd0, r);
        check("loop_byte0", r.d_data, 32'hA3);
        poll_rx();
        bus(TL_GET, 32'h0, 4'hF, 32'd0, r);
        check("loop_byte1", r.d_data, 32'h3C);
        repeat (10) @(negedge clock);
        bus(TL_GET, 32'h4, 4'hF, 32'd0, r);
        check("loop_status_final", r.d_data, 32'h0A);

        // Nine bytes into an eight-entry RX FIFO.
        for (int i = 0; i < 9; i++) bus(TL_PUT_FULL, 32'h0, 4'h1, 32'h10 + 32'(i), r);
        repeat (450) @(negedge clock);
        check("ovr_irq", 32'(irq), 32'd1);
        bus(TL_GET, 32'h4, 4'hF, 32'd0, r);
        check("ovr_status1", r.d_data, 32'h16);
        bus(TL_GET, 32'h4, 4'hF, 32'd0, r);
        check("ovr_status2", r.d_data, 32'h06);
        for (int i = 0; i < 8; i++) begin
            bus(TL_GET, 32'h0, 4'hF, 32'd0, r);
            check("ovr_byte", r.d_data, 32'h10 + 32'(i));
        end
        bus(TL_GET, 32'h4, 4'hF, 32'd0, r);
        check("ovr_status_drained", r.d_data, 32'h0A);
        repeat (2) @(negedge clock);
        check("irq_cleared", 32'(irq), 32'd0);

        // Response held while d_ready is low.
        d_ready = 1'b0;
        bus(TL_GET, 32'h8, 4'hF, 32'd0, r);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(tld.d_valid), 32'd1);
            check("hold_data", tld.d_data, 32'd3);
            check("hold_opcode", 32'(tld.d_opcode), 32'(TL_ACCESS_ACK_DATA));
            check("hold_a_ready", 32'(a_ready), 32'd0);
            @(negedge clock);
        end
        d_ready = 1'b1;
        @(negedge clock);
        check("release_a_ready", 32'(a_ready), 32'd1);
        check("release_d_valid", 32'(tld.d_valid), 32'd0);

        // Reset in the middle of a transmitted byte.
        loop_en = 1'b0;
        bus(TL_PUT_FULL, 32'h0, 4'h1, 32'h00, r);
        wait_tx_fall();
        repeat (8) @(negedge clock);
        check("mid_data_low", 32'(uart_tx), 32'd0);
        reset = 1'b1;
        #1;
        check("midrst_uart_tx", 32'(uart_tx), 32'd1);
        check("midrst_d_valid", 32'(tld.d_valid), 32'd0);
        check("midrst_a_ready", 32'(a_ready), 32'd0);
        repeat (2) @(negedge clock);
        check("midrst_uart_tx_hold", 32'(uart_tx), 32'd1);
        reset = 1'b0;
        bus(TL_GET, 32'h8, 4'hF, 32'd0, r);
        check("midrst_div", r.d_data, 32'd15);
        bus(TL_GET, 32'h4, 4'hF, 32'd0, r);
        check("midrst_status", r.d_data, 32'h0A);
        check("midrst_tx_idle", 32'(uart_tx), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
